// File: rtl/io_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: command byte layout, direction codes, FSM states.
package io_cmd_pkg;

  localparam int N_MOD_DEF = 4;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  // Command byte, MSB first: dir | module select | ioc
  typedef struct packed {
    logic       dir;
    logic [1:0] sel;
    logic [4:0] ioc;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_FETCH,
    ST_WAIT,
    ST_DATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/io_cmd_decoder_if.sv
// Raw SPI host pins; the host drives through master, the device front-end samples through slave.
interface io_cmd_decoder_if;
  logic sck;
  logic cs_n;
  logic mosi;

  modport master (output sck, output cs_n, output mosi);
  modport slave  (input  sck, input  cs_n, input  mosi);
endinterface

// File: rtl/io_cmd_decoder_sync.sv
// Brings asynchronous SPI pins into the system clock domain: 2-flop sync plus edge pulses.
// Fixed 2-cycle sync delay; no backpressure. Flops reset low so a CS_n held low never looks like a falling edge.
module spi_pin_sync (
  input  logic                   i_clk,
  input  logic                   i_reset,
  io_cmd_decoder_if.slave        pins,
  output logic                   o_sck_rise,
  output logic                   o_sck_fall,
  output logic                   o_cs_rise,
  output logic                   o_cs_fall,
  output logic                   o_mosi
);

  logic [2:0] r_sck;
  logic [2:0] r_cs_n;
  logic [1:0] r_mosi;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sck  <= '0;
      r_cs_n <= '0;
      r_mosi <= '0;
    end else begin
      r_sck  <= {r_sck[1:0], pins.sck};
      r_cs_n <= {r_cs_n[1:0], pins.cs_n};
      r_mosi <= {r_mosi[0], pins.mosi};
    end
  end

  assign o_sck_rise = r_sck[1] & ~r_sck[2];
  assign o_sck_fall = ~r_sck[1] & r_sck[2];
  assign o_cs_rise  = r_cs_n[1] & ~r_cs_n[2];
  assign o_cs_fall  = ~r_cs_n[1] & r_cs_n[2];
  assign o_mosi     = r_mosi[1];

endmodule

// File: rtl/io_cmd_decoder.sv
// SPI command front-end: decodes byte0 into select/ioc/dir, drives cs/fetch/load strobes, returns read data on MISO.
// cs and fetch 1 cycle after the 8th detected SCK rise; load/data 1 cycle after the 16th; no backpressure.
module io_cmd_decoder
  import io_cmd_pkg::*;
#(
  parameter int N_MOD = N_MOD_DEF
) (
  input  logic               i_sys_clk,
  input  logic               i_reset,
  input  logic               i_spi_sck,
  input  logic               i_spi_cs_n,
  input  logic               i_spi_mosi,
  output logic               o_spi_miso,
  output logic [4:0]         o_ioc,
  output logic [7:0]         o_data,
  output logic [N_MOD-1:0]   o_cs,
  output logic               o_fetch_cmd,
  output logic               o_load_cmd,
  input  logic [8*N_MOD-1:0] i_mod_data,
  output logic               o_busy
);

  io_cmd_decoder_if u_pins ();
  assign u_pins.sck  = i_spi_sck;
  assign u_pins.cs_n = i_spi_cs_n;
  assign u_pins.mosi = i_spi_mosi;

  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_mosi;

  spi_pin_sync u_sync (
    .i_clk      (i_sys_clk),
    .i_reset    (i_reset),
    .pins       (u_pins),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_rise  (w_cs_rise),
    .o_cs_fall  (w_cs_fall),
    .o_mosi     (w_mosi)
  );

  state_t           r_state, w_next_state;
  logic [2:0]       r_bit_cnt;
  logic [6:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  cmd_t             w_cmd;
  logic             w_byte_done, w_latch_cmd, w_load;
  logic             r_dir;
  logic [1:0]       r_sel;
  logic [4:0]       r_ioc;
  logic [7:0]       r_data;
  logic [N_MOD-1:0] r_cs, w_cs_onehot;
  logic             r_load;
  logic [7:0]       r_miso_sr;
  logic             r_miso;
  logic [7:0]       w_rd_byte;

  assign w_shift_nxt = {r_shift, w_mosi};
  assign w_cmd       = w_shift_nxt;
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_cs_onehot = N_MOD'(1) << w_cmd.sel;
  assign w_rd_byte   = i_mod_data[{r_sel, 3'b000} +: 8];

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // A CS_n rise overrides anything else happening in the same cycle.
  always_comb begin
    w_next_state = r_state;
    w_latch_cmd  = 1'b0;
    w_load       = 1'b0;
    if (w_cs_rise) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_cs_fall) w_next_state = ST_CMD;
        ST_CMD: begin
          if (w_byte_done) begin
            w_latch_cmd  = 1'b1;
            w_next_state = (w_cmd.dir == DIR_WRITE) ? ST_DATA : ST_FETCH;
          end
        end
        ST_FETCH: w_next_state = ST_WAIT;
        ST_WAIT:  w_next_state = ST_DATA;
        ST_DATA: begin
          if (w_byte_done) begin
            w_load       = (r_dir == DIR_WRITE);
            w_next_state = ST_DONE;
          end
        end
        ST_DONE:  w_next_state = ST_DONE;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_dir     <= DIR_READ;
      r_sel     <= '0;
      r_ioc     <= '0;
      r_data    <= '0;
      r_cs      <= '0;
      r_load    <= 1'b0;
      r_miso_sr <= '0;
      r_miso    <= 1'b0;
    end else begin
      r_load <= w_load;

      if (r_state == ST_IDLE) begin
        r_bit_cnt <= '0;
      end else if (w_sck_rise && !w_cs_rise && (r_state == ST_CMD || r_state == ST_DATA)) begin
        r_shift   <= w_shift_nxt[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (w_next_state == ST_IDLE) begin
        r_cs <= '0;
      end else if (w_latch_cmd) begin
        r_cs  <= w_cs_onehot;
        r_ioc <= w_cmd.ioc;
        r_sel <= w_cmd.sel;
        r_dir <= w_cmd.dir;
      end

      if (w_load) r_data <= w_shift_nxt;

      // Writes never load the shifter, so MISO stays low for them.
      if (w_latch_cmd)                            r_miso_sr <= '0;
      else if (r_state == ST_WAIT)                r_miso_sr <= w_rd_byte;
      else if (r_state == ST_DATA && w_sck_fall)  r_miso_sr <= {r_miso_sr[6:0], 1'b0};

      if (w_next_state != ST_DATA) r_miso <= 1'b0;
      else if (w_sck_fall)         r_miso <= r_miso_sr[7];
    end
  end

  assign o_spi_miso  = r_miso;
  assign o_ioc       = r_ioc;
  assign o_data      = r_data;
  assign o_cs        = r_cs;
  assign o_fetch_cmd = (r_state == ST_FETCH);
  assign o_load_cmd  = r_load;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_io_cmd_decoder.sv
// Scoreboard bench for io_cmd_decoder: bit-banged SPI host, strobe/MISO monitor, module read-data model.
module tb_io_cmd_decoder;

  localparam time HP = 100ns;

  logic        clk;
  logic        rst;
  logic        miso;
  logic [4:0]  ioc;
  logic [7:0]  data;
  logic [3:0]  cs;
  logic        fetch;
  logic        load;
  logic [31:0] mod_data;
  logic        busy;

  io_cmd_decoder_if spi ();

  io_cmd_decoder #(.N_MOD(4)) dut (
    .i_sys_clk   (clk),
    .i_reset     (rst),
    .i_spi_sck   (spi.sck),
    .i_spi_cs_n  (spi.cs_n),
    .i_spi_mosi  (spi.mosi),
    .o_spi_miso  (miso),
    .o_ioc       (ioc),
    .o_data      (data),
    .o_cs        (cs),
    .o_fetch_cmd (fetch),
    .o_load_cmd  (load),
    .i_mod_data  (mod_data),
    .o_busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5ns clk = ~clk;
  end

  typedef struct {
    bit         is_load;
    logic [4:0] ioc;
    logic [7:0] data;
    logic [3:0] cs;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_miso[$];
  logic [7:0] rx_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] mod_resp [4] = '{8'h01, 8'h33, 8'h5C, 8'h77};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit l, input logic [4:0] i, input logic [7:0] d, input logic [3:0] c);
    ev_t e;
    e.is_load = l; e.ioc = i; e.data = d; e.cs = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe and every completed MISO byte is matched against the scoreboard.
  initial begin
    ev_t e;
    logic [7:0] r;
    forever begin
      @(negedge clk);
      if (load || fetch) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: got load=%0b fetch=%0b expected none at %0t", load, fetch, $time);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", {30'd0, load, fetch}, e.is_load ? 32'd2 : 32'd1);
          chk("strobe_ioc", 32'(ioc), 32'(e.ioc));
          chk("strobe_data", 32'(data), 32'(e.data));
          chk("strobe_cs", 32'(cs), 32'(e.cs));
        end
      end
      while (rx_q.size() > 0) begin
        r = rx_q.pop_front();
        if (exp_miso.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_miso_byte: got 0x%0h expected none", r);
        end else begin
          chk("miso_byte", 32'(r), 32'(exp_miso.pop_front()));
        end
      end
    end
  end

  // Module model: selected module presents its byte one cycle after the fetch strobe.
  initial begin
    mod_data = 32'hEEEE_EEEE;
    forever begin
      @(negedge clk);
      if (fetch) begin
        @(posedge clk); #1ns;
        for (int k = 0; k < 4; k++)
          if (cs[k]) mod_data[8*k +: 8] = mod_resp[k];
      end else if (cs == 4'b0000) begin
        mod_data = 32'hEEEE_EEEE;
      end
    end
  end

  task automatic clock_bits(input logic [23:0] tx, input int n, input bit record);
    logic [7:0] rx;
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi.mosi = tx[23-i];
      #(HP);
      rx = {rx[6:0], miso};
      spi.sck = 1'b1;
      #(HP);
      spi.sck = 1'b0;
      if (record && (i % 8 == 7)) rx_q.push_back(rx);
    end
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int nbits, input logic [3:0] exp_cs);
    spi.cs_n = 1'b0;
    #(HP);
    clock_bits({b0, b1, b2}, nbits, 1'b1);
    #(HP);
    chk("cs_in_frame", 32'(cs), 32'(exp_cs));
    chk("busy_in_frame", 32'(busy), 32'd1);
    spi.cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1ns;
    chk("cs_after_frame", 32'(cs), 32'd0);
    chk("busy_after_frame", 32'(busy), 32'd0);
    #(4*HP);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"}, 32'(miso), 32'd0);
    chk({tag, "_ioc"}, 32'(ioc), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_cs"}, 32'(cs), 32'd0);
    chk({tag, "_fetch"}, 32'(fetch), 32'd0);
    chk({tag, "_load"}, 32'(load), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    spi.cs_n = 1'b1;
    spi.sck  = 1'b0;
    spi.mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1ns;
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1ns;

    // Write module 0 ioc 4 with 0xA5
    push_ev(1'b1, 5'd4, 8'hA5, 4'b0001);
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    run_frame(8'h84, 8'hA5, 8'h00, 16, 4'b0001);

    // Read module 0 ioc 1; o_data keeps the last write
    push_ev(1'b0, 5'd1, 8'hA5, 4'b0001);
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h01);
    run_frame(8'h01, 8'h00, 8'h00, 16, 4'b0001);

    // Read module 2 ioc 3
    push_ev(1'b0, 5'd3, 8'hA5, 4'b0100);
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h5C);
    run_frame(8'h43, 8'h00, 8'h00, 16, 4'b0100);

    // Aborted write: only 5 bits of byte1
    exp_miso.push_back(8'h00);
    run_frame(8'h84, 8'hFF, 8'h00, 13, 4'b0001);
    chk("abort_data_held", 32'(data), 32'hA5);

    // Three-byte write: trailing byte ignored
    push_ev(1'b1, 5'd4, 8'h11, 4'b0001);
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    run_frame(8'h84, 8'h11, 8'h22, 24, 4'b0001);

    // Reset during byte1 of a write, CS_n held low throughout
    spi.cs_n = 1'b0;
    #(HP);
    clock_bits({8'h84, 8'hC3, 8'h00}, 11, 1'b0);
    @(posedge clk); #1ns;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1ns;
    chk_reset_vals("midreset");
    rst = 1'b0;
    #(HP);
    clock_bits({8'h84, 8'h5A, 8'h00}, 16, 1'b0);
    #(HP);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_cs", 32'(cs), 32'd0);
    spi.cs_n = 1'b1;
    #(4*HP);

    // Fresh frame after CS_n has cycled: write module 1 ioc 7
    push_ev(1'b1, 5'd7, 8'h3C, 4'b0010);
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    run_frame(8'hA7, 8'h3C, 8'h00, 16, 4'b0010);

    repeat (5) @(negedge clk);
    chk("pending_strobes", 32'(exp_q.size()), 32'd0);
    chk("pending_miso", 32'(exp_miso.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
